// File: rtl/iob_pfsm_core_pkg.sv
// Shared definitions for the programmable FSM engine.
// Holds the CSR word map, the CTRL bit positions and the per-cycle engine action.
package iob_pfsm_core_pkg;

  localparam int CSR_CTRL   = 0;
  localparam int CSR_STATUS = 1;
  localparam int CSR_OUT_EN = 2;
  localparam int CSR_TRANS  = 3;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_STEP     = 1;
  localparam int CTRL_SOFT_RST = 2;

  localparam int TRANS_W = 32;

  // What the state/output/counter registers do on a given edge.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_FIRE,
    ACT_CLEAR
  } act_e;

endpackage

// File: rtl/iob_pfsm_core_if.sv
// IOb native bus bundle between a host (master) and the PFSM engine (slave).
// Requests are always accepted; read data returns one cycle after the request.
interface iob_pfsm_core_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic                  iob_avalid_i;
  logic [ADDR_W-1:0]     iob_addr_i;
  logic [DATA_W-1:0]     iob_wdata_i;
  logic [DATA_W/8-1:0]   iob_wstrb_i;
  logic                  iob_rvalid_o;
  logic [DATA_W-1:0]     iob_rdata_o;
  logic                  iob_ready_o;

  modport master (
    output iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_rvalid_o, iob_rdata_o, iob_ready_o
  );

  modport slave (
    input  iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_rvalid_o, iob_rdata_o, iob_ready_o
  );

endinterface

// File: rtl/iob_pfsm_core_lut.sv
// Transition/output table: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; a read in the same cycle still sees the old entry. No backpressure.
module iob_pfsm_core_lut #(
  parameter int IDX_W = 3,
  parameter int ENT_W = 4
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             wr_vld_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [ENT_W-1:0] wr_dat_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [ENT_W-1:0] rd_dat_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_vld_i && (wr_idx_i == IDX_W'(i))) mem_d[i] = wr_dat_i;
    end
  end

  // Contents are software-loaded, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_dat_o = mem_q[rd_idx_i];

endmodule

// File: rtl/iob_pfsm_core.sv
// Programmable FSM engine: LUT-driven state machine with run/step/soft-reset control behind IOb.
// Reads return one cycle after the request; ready is tied high, so there is never backpressure.
module iob_pfsm_core
  import iob_pfsm_core_pkg::*;
#(
  parameter int STATE_W  = 2,
  parameter int INPUT_W  = 1,
  parameter int OUTPUT_W = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  iob_pfsm_core_if.slave      iob,
  input  logic [INPUT_W-1:0]  input_ports_i,
  output logic [OUTPUT_W-1:0] output_ports_o,
  output logic [OUTPUT_W-1:0] output_enable_o
);

  localparam int IDX_W = STATE_W + INPUT_W;
  localparam int ENT_W = STATE_W + OUTPUT_W;

  logic [STATE_W-1:0]  state_q,   state_d;
  logic [OUTPUT_W-1:0] out_q,     out_d;
  logic [OUTPUT_W-1:0] oen_q,     oen_d;
  logic [TRANS_W-1:0]  trans_q,   trans_d;
  logic                run_q,     run_d;
  logic                step_q,    step_d;
  logic [INPUT_W-1:0]  in_meta_q, in_meta_d;
  logic [INPUT_W-1:0]  in_s_q,    in_s_d;
  logic                rvalid_q,  rvalid_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;

  logic                req_wr, req_rd, sel_lut;
  logic                ctrl_wr, oen_wr, lut_we;
  logic [ADDR_W-4:0]   word_idx;
  logic [ENT_W-1:0]    lut_rdat;
  act_e                act;
  logic                unused_bits;

  assign req_wr   = iob.iob_avalid_i && (|iob.iob_wstrb_i);
  assign req_rd   = iob.iob_avalid_i && !(|iob.iob_wstrb_i);
  assign sel_lut  = iob.iob_addr_i[ADDR_W-1];
  assign word_idx = iob.iob_addr_i[ADDR_W-2:2];
  assign ctrl_wr  = req_wr && !sel_lut && (int'(word_idx) == CSR_CTRL);
  assign oen_wr   = req_wr && !sel_lut && (int'(word_idx) == CSR_OUT_EN);
  assign lut_we   = req_wr && sel_lut;

  assign unused_bits = ^{iob.iob_wdata_i, iob.iob_addr_i[1:0]};

  iob_pfsm_core_lut #(
    .IDX_W (IDX_W),
    .ENT_W (ENT_W)
  ) u_lut (
    .clk_i    (clk_i),
    .cke_i    (cke_i),
    .wr_vld_i (lut_we),
    .wr_idx_i (iob.iob_addr_i[IDX_W+1:2]),
    .wr_dat_i (iob.iob_wdata_i[ENT_W-1:0]),
    .rd_idx_i ({state_q, in_s_q}),
    .rd_dat_o (lut_rdat)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    oen_d     = oen_q;
    trans_d   = trans_q;
    run_d     = run_q;
    step_d    = 1'b0;
    in_meta_d = input_ports_i;
    in_s_d    = in_meta_q;
    rvalid_d  = req_rd;
    rdata_d   = '0;

    // Soft reset from the bus beats any transition due on the same edge.
    act = ACT_HOLD;
    if (ctrl_wr && iob.iob_wdata_i[CTRL_SOFT_RST]) act = ACT_CLEAR;
    else if (run_q || step_q)                     act = ACT_FIRE;

    if (ctrl_wr) begin
      run_d  = iob.iob_wdata_i[CTRL_RUN];
      // A step only means something when the engine is left halted by this write.
      step_d = iob.iob_wdata_i[CTRL_STEP] && !iob.iob_wdata_i[CTRL_RUN] &&
               !iob.iob_wdata_i[CTRL_SOFT_RST];
    end
    if (oen_wr) oen_d = iob.iob_wdata_i[OUTPUT_W-1:0];

    case (act)
      ACT_CLEAR: begin
        state_d = '0;
        out_d   = '0;
        trans_d = '0;
      end
      ACT_FIRE: begin
        state_d = lut_rdat[ENT_W-1:OUTPUT_W];
        out_d   = lut_rdat[OUTPUT_W-1:0];
        trans_d = trans_q + TRANS_W'(1);
      end
      default: ;
    endcase

    if (req_rd && !sel_lut) begin
      case (int'(word_idx))
        CSR_STATUS: begin
          rdata_d[STATE_W-1:0] = state_q;
          rdata_d[DATA_W-1]    = run_q;
        end
        CSR_OUT_EN: rdata_d[OUTPUT_W-1:0] = oen_q;
        CSR_TRANS:  rdata_d[TRANS_W-1:0]  = trans_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= '0;
      out_q     <= '0;
      oen_q     <= '0;
      trans_q   <= '0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      in_meta_q <= '0;
      in_s_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else if (cke_i) begin
      state_q   <= state_d;
      out_q     <= out_d;
      oen_q     <= oen_d;
      trans_q   <= trans_d;
      run_q     <= run_d;
      step_q    <= step_d;
      in_meta_q <= in_meta_d;
      in_s_q    <= in_s_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign iob.iob_ready_o  = 1'b1;
  assign iob.iob_rvalid_o = rvalid_q;
  assign iob.iob_rdata_o  = rdata_q;
  assign output_ports_o   = out_q;
  assign output_enable_o  = oen_q;

endmodule
